alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 8-output ALU: accept, execute, respond.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req0_op,
  input  logic [2:0] req1_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out0,
  input  logic [7:0] alu_out1,
  input  logic [7:0] alu_out2,
  input  logic [7:0] alu_out3,
  input  logic [7:0] alu_out4,
  input  logic [7:0] alu_out5,
  input  logic [7:0] alu_out6,
  input  logic [7:0] alu_out7,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic       id_q, id_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_id_q, rsp_id_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] done_cnt_q, done_cnt_d;
  logic       grant;
  logic [7:0] alu_sel;

  // On a tie the requester not served last wins; otherwise the only valid one.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state_q == IDLE) && !rst && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && !rst && req1_valid &&  grant;

  always_comb begin
    case (op_q)
      3'd0:    alu_sel = alu_out0;
      3'd1:    alu_sel = alu_out1;
      3'd2:    alu_sel = alu_out2;
      3'd3:    alu_sel = alu_out3;
      3'd4:    alu_sel = alu_out4;
      3'd5:    alu_sel = alu_out5;
      3'd6:    alu_sel = alu_out6;
      default: alu_sel = alu_out7;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          a_d          = grant ? req1_a  : req0_a;
          b_d          = grant ? req1_b  : req0_b;
          op_d         = grant ? req1_op : req0_op;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_sel;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          done_cnt_d = done_cnt_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an ALU stub where OutN = A + B + N (mod 256).
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out0, alu_out1, alu_out2, alu_out3;
  logic [7:0] alu_out4, alu_out5, alu_out6, alu_out7;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data, done_cnt;

  always #5 clk = ~clk;

  assign alu_out0 = alu_a + alu_b + 8'd0;
  assign alu_out1 = alu_a + alu_b + 8'd1;
  assign alu_out2 = alu_a + alu_b + 8'd2;
  assign alu_out3 = alu_a + alu_b + 8'd3;
  assign alu_out4 = alu_a + alu_b + 8'd4;
  assign alu_out5 = alu_a + alu_b + 8'd5;
  assign alu_out6 = alu_a + alu_b + 8'd6;
  assign alu_out7 = alu_a + alu_b + 8'd7;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_out0(alu_out0), .alu_out1(alu_out1), .alu_out2(alu_out2), .alu_out3(alu_out3),
    .alu_out4(alu_out4), .alu_out5(alu_out5), .alu_out6(alu_out6), .alu_out7(alu_out7),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .done_cnt(done_cnt)
  );

  typedef struct {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cnt_model = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every response handshake is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected actual id=%0d data=%0d required=none", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk("done_cnt_at_hs", {24'd0, done_cnt}, {24'd0, cnt_model});
        end
        cnt_model = cnt_model + 8'd1;
      end
    end
  end

  task automatic drive_req(input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
    if (r == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // Called just after a negedge with inputs applied; returns in the accept cycle.
  task automatic wait_grant(input int r);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((r == 0) ? req0_ready : req1_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout req%0d actual=no_ready required=ready", r);
    end else begin
      chk("other_ready_low", {31'd0, (r == 0) ? req1_ready : req0_ready}, 32'd0);
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    cnt_model = '0;
  endtask

  initial begin
    logic [7:0] hold_cnt;
    logic [7:0] f_a [6] = '{8'd10, 8'd100, 8'd200, 8'd7, 8'd255, 8'd1};
    logic [7:0] f_b [6] = '{8'd20, 8'd100, 8'd50,  8'd8, 8'd255, 8'd2};
    logic [2:0] f_op[6] = '{3'd1,  3'd2,   3'd6,   3'd5, 3'd4,   3'd0};
    logic [7:0] f_r [6] = '{8'd31, 8'd202, 8'd0,   8'd20, 8'd2,  8'd3};

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 8'd5; req0_b = 8'd6; req0_op = 3'd0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b1;

    // Reset state, with a requester already valid during reset.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ready0_in_reset", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_done_cnt", {24'd0, done_cnt}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);

    // Single op with exact latency.
    @(negedge clk);
    push(1'b0, 8'd11);
    drive_req(0, 8'd5, 8'd6, 3'd0);
    wait_grant(0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("lat_t1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_t1_alu_a", {24'd0, alu_a}, 32'd5);
    chk("lat_t1_alu_b", {24'd0, alu_b}, 32'd6);
    @(negedge clk);
    #1;
    chk("lat_t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lat_t2_rsp_data", {24'd0, rsp_data}, 32'd11);
    @(negedge clk);
    #1;
    chk("single_done_cnt", {24'd0, done_cnt}, 32'd1);

    // Tie straight out of reset: requester 0 first, then 1 with wrapped sum.
    pulse_reset();
    push(1'b0, 8'd18);
    push(1'b1, 8'd7);
    drive_req(0, 8'd5, 8'd6, 3'd7);
    drive_req(1, 8'd250, 8'd10, 3'd3);
    wait_grant(0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_grant(1);
    @(negedge clk);
    req1_valid = 1'b0;
    drain();

    // Fairness: both held valid for six ops, grants must alternate 0,1,...
    drive_req(0, f_a[0], f_b[0], f_op[0]);
    drive_req(1, f_a[1], f_b[1], f_op[1]);
    for (int i = 0; i < 6; i++) push(1'(i % 2), f_r[i]);
    for (int i = 0; i < 6; i++) begin
      wait_grant(i % 2);
      @(negedge clk);
      if (i + 2 < 6) drive_req(i % 2, f_a[i + 2], f_b[i + 2], f_op[i + 2]);
      else if (i % 2 == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
    end
    drain();

    // Backpressure: response held five cycles while another requester waits.
    rsp_ready = 1'b0;
    push(1'b1, 8'd9);
    drive_req(1, 8'd3, 8'd4, 3'd2);
    wait_grant(1);
    @(negedge clk);
    req1_valid = 1'b0;
    drive_req(0, 8'd1, 8'd1, 3'd1);
    hold_cnt = done_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_data", {24'd0, rsp_data}, 32'd9);
      chk("bp_rsp_id", {31'd0, rsp_id}, 32'd1);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
      chk("bp_done_cnt", {24'd0, done_cnt}, {24'd0, hold_cnt});
      chk("bp_alu_a", {24'd0, alu_a}, 32'd3);
    end
    push(1'b0, 8'd3);
    rsp_ready = 1'b1;
    wait_grant(0);
    @(negedge clk);
    req0_valid = 1'b0;
    drain();

    // Reset during EXEC aborts the op; following tie goes to requester 0.
    drive_req(0, 8'd9, 8'd9, 3'd0);
    wait_grant(0);
    @(negedge clk);
    rst = 1'b1;
    drive_req(0, 8'd5, 8'd6, 3'd7);
    drive_req(1, 8'd250, 8'd10, 3'd3);
    #1;
    chk("rst_mid_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_mid_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    cnt_model = '0;
    push(1'b0, 8'd18);
    push(1'b1, 8'd7);
    #1;
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_done_cnt", {24'd0, done_cnt}, 32'd0);
    chk("rst_mid_alu_a", {24'd0, alu_a}, 32'd0);
    wait_grant(0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_grant(1);
    @(negedge clk);
    req1_valid = 1'b0;
    drain();

    // Counter wrap over 256 handshakes.
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      push(1'b0, 8'(i + 1 + (i % 8)));
      drive_req(0, 8'(i), 8'd1, 3'(i % 8));
      wait_grant(0);
      @(negedge clk);
      req0_valid = 1'b0;
      if (i == 254) begin
        drain();
        chk("wrap_cnt_255", {24'd0, done_cnt}, 32'd255);
      end
    end
    drain();
    chk("wrap_cnt_0", {24'd0, done_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
